// File: rtl/mul.sv
// Unsigned 8x8 multiplier for the CNN MAC datapath: w (weight) times x (activation),
// registered 16-bit product, one operand pair accepted per clock with no handshake.
module mul (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  w,
    input  logic [7:0]  x,
    output logic [15:0] y
);

    logic [15:0] pp [8];
    logic [15:0] sum_l1 [4];
    logic [15:0] sum_l2 [2];
    logic [15:0] y_d;
    logic [15:0] y_q;

    // Partial products: row i is w gated by x[i], weighted by 2^i.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pp[i] = {8'b0, (w & {8{x[i]}})} << i;
        end
    end

    // Every partial sum is bounded by the full product, so 16 bits never overflow.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum_l1[i] = pp[2*i] + pp[2*i+1];
        end
        for (int i = 0; i < 2; i++) begin
            sum_l2[i] = sum_l1[2*i] + sum_l1[2*i+1];
        end
        y_d = sum_l2[0] + sum_l2[1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_q <= 16'h0000;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul: inputs are driven on the falling edge and y is sampled
// on the falling edge (or a few ns after a rising edge), against an arithmetic reference.
module tb_mul;

    logic        clk;
    logic        rstn;
    logic [7:0]  w;
    logic [7:0]  x;
    logic [15:0] y;

    int n_checks;
    int n_fail;

    mul dut (
        .clk  (clk),
        .rstn (rstn),
        .w    (w),
        .x    (x),
        .y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input int a, input int b);
        int p;
        p = a * b;
        return p[15:0];
    endfunction

    task automatic test_reset();
        rstn = 1'b1;
        w    = 8'h00;
        x    = 8'h00;
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if (y !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_immediate: y=%h expected=%h", y, 16'h0000);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (y !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_zero_ops cycle %0d: y=%h expected=%h", i, y, 16'h0000);
            end
        end
        w = 8'hFF;
        x = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (y !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_max_ops cycle %0d: y=%h expected=%h", i, y, 16'h0000);
            end
        end
    endtask

    // Releases reset at a falling edge, so the very next rising edge captures w=4, x=0.
    task automatic test_sweep();
        logic [15:0] exp_y;
        rstn = 1'b1;
        w    = 8'd4;
        x    = 8'd0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_y = ref_mul(4, i);
            n_checks++;
            if (y !== exp_y) begin
                n_fail++;
                $display("FAIL sweep x=%0d: y=%h expected=%h", i, y, exp_y);
            end
            if (i < 15) x = 8'(i + 1);
        end
    endtask

    task automatic test_idle();
        w = 8'h00;
        x = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (y !== 16'h0000) begin
                n_fail++;
                $display("FAIL idle cycle %0d: y=%h expected=%h", i, y, 16'h0000);
            end
        end
    endtask

    task automatic test_corners();
        int          wa [7];
        int          xa [7];
        logic [15:0] ea [7];
        wa = '{255, 255,   1, 128,   0, 200,  16};
        xa = '{255,   1, 255,   2, 200,   0,  16};
        ea = '{16'hFE01, 16'h00FF, 16'h00FF, 16'h0100, 16'h0000, 16'h0000, 16'h0100};
        for (int i = 0; i < 7; i++) begin
            w = 8'(wa[i]);
            x = 8'(xa[i]);
            @(negedge clk);
            n_checks++;
            if (y !== ea[i]) begin
                n_fail++;
                $display("FAIL corner %0d*%0d: y=%h expected=%h", wa[i], xa[i], y, ea[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q [$];
        logic [15:0] exp_y;
        int          a;
        int          b;
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if (i % 97 == 5)  a = 0;
            if (i % 89 == 11) b = 0;
            w = 8'(a);
            x = 8'(b);
            exp_q.push_back(ref_mul(a, b));
            @(negedge clk);
            exp_y = exp_q.pop_front();
            n_checks++;
            if (y !== exp_y) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d (%0d*%0d): y=%h expected=%h",
                         i, a, b, y, exp_y);
            end
        end
    endtask

    task automatic test_async_reset();
        w = 8'hFF;
        x = 8'hFF;
        @(posedge clk);
        #2;
        n_checks++;
        if (y !== 16'hFE01) begin
            n_fail++;
            $display("FAIL async_pre: y=%h expected=%h", y, 16'hFE01);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (y !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_drop: y=%h expected=%h", y, 16'h0000);
        end
        rstn = 1'b1;
        w    = 8'd3;
        x    = 8'd7;
        @(negedge clk);
        n_checks++;
        if (y !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_hold: y=%h expected=%h", y, 16'h0000);
        end
        @(negedge clk);
        n_checks++;
        if (y !== ref_mul(3, 7)) begin
            n_fail++;
            $display("FAIL async_recover: y=%h expected=%h", y, ref_mul(3, 7));
        end
        w = 8'd200;
        x = 8'd201;
        @(negedge clk);
        n_checks++;
        if (y !== ref_mul(200, 201)) begin
            n_fail++;
            $display("FAIL async_follow: y=%h expected=%h", y, ref_mul(200, 201));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sweep();
        test_idle();
        test_corners();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
